// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: forwarding mux codes,
// stall FSM states and the default register index width.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned X0             = 0;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_ME = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/forward_select.sv
// Single-source EX operand forwarding comparator; ME result takes priority over WB.
module forward_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] me_rd,
    input  logic                  me_ruwr,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_ruwr,
    output fwd_sel_e              fwd_sel
);

    logic me_hit;
    logic wb_hit;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value
    assign me_hit = me_ruwr && (me_rd != REG_ADDR_W'(X0)) && (me_rd == ex_rs);
    assign wb_hit = wb_ruwr && (wb_rd != REG_ADDR_W'(X0)) && (wb_rd == ex_rs);

    always_comb begin
        fwd_sel = FWD_RF;
        if (me_hit) begin
            fwd_sel = FWD_ME;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall FSM and branch flush.
// Optional saturating perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_ruwr,
    input  logic                          ex_is_load,
    input  logic [REG_ADDR_W-1:0]         me_rd,
    input  logic                          me_ruwr,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          wb_ruwr,
    input  logic                          br_taken,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          pc_stall,
    output logic                          if_id_stall,
    output logic                          if_id_flush,
    output logic                          id_ex_flush,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_cycles
);

    localparam logic [2:0] LatM1 = 3'(LOAD_LAT - 1);

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
        fwd_sel_e fwd_raw;

        forward_select #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_fwd (
            .ex_rs   (ex_rs[g*REG_ADDR_W +: REG_ADDR_W]),
            .me_rd   (me_rd),
            .me_ruwr (me_ruwr),
            .wb_rd   (wb_rd),
            .wb_ruwr (wb_ruwr),
            .fwd_sel (fwd_raw)
        );

        assign fwd_sel[2*g +: 2] = rst_n ? fwd_raw : FWD_RF;
    end

    logic lu_hit;
    logic lu;

    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            lu_hit = lu_hit | (ex_rd == id_rs[i*REG_ADDR_W +: REG_ADDR_W]);
        end
    end

    assign lu = ex_is_load && ex_ruwr && (ex_rd != REG_ADDR_W'(X0)) && lu_hit;

    hz_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stall;
    logic       flush;

    // The first bubble is raised combinationally from IDLE; STALL covers the remaining ones
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        if (br_taken) begin
            flush   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lu) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = LatM1;
                        end
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_stall    = rst_n & stall;
    assign if_id_stall = rst_n & stall;
    assign if_id_flush = rst_n & flush;
    assign id_ex_flush = rst_n & (stall | flush);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: one instance with LOAD_LAT=3 and one with LOAD_LAT=1
// share stimulus; expectations flow through a scoreboard queue.
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [9:0]  id_rs;
    logic [9:0]  ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_ruwr;
    logic        ex_is_load;
    logic [4:0]  me_rd;
    logic        me_ruwr;
    logic [4:0]  wb_rd;
    logic        wb_ruwr;
    logic        br_taken;

    logic [3:0]  fwd3, fwd1;
    logic        pcs3, ifs3, iff3, ief3;
    logic        pcs1, ifs1, iff1, ief1;
    logic [31:0] stall3, flushc3, stall1, flushc1;
    logic [3:0]  ctl3, ctl1;

    assign ctl3 = {pcs3, ifs3, iff3, ief3};
    assign ctl1 = {pcs1, ifs1, iff1, ief1};

    hazard_unit #(
        .REG_ADDR_W (5),
        .NUM_SRC    (2),
        .LOAD_LAT   (3),
        .CNT_W      (32)
    ) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .ex_rs        (ex_rs),
        .ex_rd        (ex_rd),
        .ex_ruwr      (ex_ruwr),
        .ex_is_load   (ex_is_load),
        .me_rd        (me_rd),
        .me_ruwr      (me_ruwr),
        .wb_rd        (wb_rd),
        .wb_ruwr      (wb_ruwr),
        .br_taken     (br_taken),
        .fwd_sel      (fwd3),
        .pc_stall     (pcs3),
        .if_id_stall  (ifs3),
        .if_id_flush  (iff3),
        .id_ex_flush  (ief3),
        .stall_cycles (stall3),
        .flush_cycles (flushc3)
    );

    hazard_unit #(
        .REG_ADDR_W (5),
        .NUM_SRC    (2),
        .LOAD_LAT   (1),
        .CNT_W      (32)
    ) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .ex_rs        (ex_rs),
        .ex_rd        (ex_rd),
        .ex_ruwr      (ex_ruwr),
        .ex_is_load   (ex_is_load),
        .me_rd        (me_rd),
        .me_ruwr      (me_ruwr),
        .wb_rd        (wb_rd),
        .wb_ruwr      (wb_ruwr),
        .br_taken     (br_taken),
        .fwd_sel      (fwd1),
        .pc_stall     (pcs1),
        .if_id_stall  (ifs1),
        .if_id_flush  (iff1),
        .id_ex_flush  (ief1),
        .stall_cycles (stall1),
        .flush_cycles (flushc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [4:0] rs0, rs1, id0, id1, erd;
        logic       ewr, eld;
        logic [4:0] mrd;
        logic       mwr;
        logic [4:0] wrd;
        logic       wwr;
        logic [3:0] efwd, ectl;
    } vec_t;

    typedef struct {
        string      nm;
        logic [3:0] fwd;
        logic [3:0] c3;
        logic [3:0] c1;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are compared at the falling edge.
    task automatic step(input string nm, input logic [3:0] ef, input logic [3:0] ec3,
                        input logic [3:0] ec1);
        exp_t e;
        e.nm = nm;
        e.fwd = ef;
        e.c3 = ec3;
        e.c1 = ec1;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({e.nm, ".fwd"}, 32'(fwd3), 32'(e.fwd));
        check({e.nm, ".ctl3"}, 32'(ctl3), 32'(e.c3));
        check({e.nm, ".ctl1"}, 32'(ctl1), 32'(e.c1));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; ex_rs = '0; ex_rd = '0; ex_ruwr = 1'b0; ex_is_load = 1'b0;
        me_rd = '0; me_ruwr = 1'b0; wb_rd = '0; wb_ruwr = 1'b0; br_taken = 1'b0;
    endtask

    task automatic set_lu();
        ex_is_load = 1'b1; ex_ruwr = 1'b1; ex_rd = 5'd5; id_rs = {5'd5, 5'd0};
    endtask

    task automatic check_perf(input string nm, input int s3, input int s1, input int f);
        check({nm, ".stall3"}, stall3, Perf ? 32'(s3) : 32'd0);
        check({nm, ".stall1"}, stall1, Perf ? 32'(s1) : 32'd0);
        check({nm, ".flush3"}, flushc3, Perf ? 32'(f) : 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"fwd_me_wb",   5'd1,  5'd2,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd1,  1'b1, 5'd2,  1'b1, 4'b1001, 4'b0000};
        vecs[1]  = '{"fwd_me_prio", 5'd1,  5'd0,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd1,  1'b1, 5'd1,  1'b1, 4'b0001, 4'b0000};
        vecs[2]  = '{"fwd_me_x0",   5'd0,  5'd0,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd0,  1'b1, 5'd0,  1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{"fwd_wb_nowr", 5'd3,  5'd0,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd0,  1'b0, 5'd3,  1'b0, 4'b0000, 4'b0000};
        vecs[4]  = '{"fwd_wb_both", 5'd3,  5'd3,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd0,  1'b0, 5'd3,  1'b1, 4'b1010, 4'b0000};
        vecs[5]  = '{"fwd_me_nowr", 5'd7,  5'd7,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd7,  1'b0, 5'd7,  1'b1, 4'b1010, 4'b0000};
        vecs[6]  = '{"fwd_me_both", 5'd4,  5'd4,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd4,  1'b1, 5'd4,  1'b1, 4'b0101, 4'b0000};
        vecs[7]  = '{"fwd_wb_x0",   5'd0,  5'd9,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd9,  1'b1, 5'd0,  1'b1, 4'b0100, 4'b0000};
        vecs[8]  = '{"fwd_miss",    5'd10, 5'd11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                     5'd12, 1'b1, 5'd13, 1'b1, 4'b0000, 4'b0000};
        vecs[9]  = '{"lu_x0",       5'd0,  5'd0,  5'd0, 5'd0, 5'd0, 1'b1, 1'b1,
                     5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, 4'b0000};
        vecs[10] = '{"lu_nowr",     5'd0,  5'd0,  5'd5, 5'd0, 5'd5, 1'b0, 1'b1,
                     5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, 4'b0000};
        vecs[11] = '{"lu_noload",   5'd0,  5'd0,  5'd5, 5'd0, 5'd5, 1'b1, 1'b0,
                     5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, 4'b0000};
        vecs[12] = '{"lu_miss",     5'd0,  5'd0,  5'd6, 5'd7, 5'd5, 1'b1, 1'b1,
                     5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, 4'b0000};

        // Reset: drive inputs that would forward and stall, outputs must still read 0
        clear_inputs();
        set_lu();
        me_rd = 5'd1; me_ruwr = 1'b1; ex_rs = {5'd0, 5'd1};
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst.fwd3", 32'(fwd3), 32'd0);
        check("rst.ctl3", 32'(ctl3), 32'd0);
        check("rst.ctl1", 32'(ctl1), 32'd0);
        check_perf("rst", 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            ex_rs = {vecs[i].rs1, vecs[i].rs0};
            id_rs = {vecs[i].id1, vecs[i].id0};
            ex_rd = vecs[i].erd; ex_ruwr = vecs[i].ewr; ex_is_load = vecs[i].eld;
            me_rd = vecs[i].mrd; me_ruwr = vecs[i].mwr;
            wb_rd = vecs[i].wrd; wb_ruwr = vecs[i].wwr;
            step(vecs[i].nm, vecs[i].efwd, vecs[i].ectl, vecs[i].ectl);
        end
        clear_inputs();

        // Single load-use pulse: LAT3 holds three bubbles, LAT1 one
        set_lu();
        step("lu_c0", 4'b0000, 4'b1101, 4'b1101);
        clear_inputs();
        step("lu_c1", 4'b0000, 4'b1101, 4'b0000);
        step("lu_c2", 4'b0000, 4'b1101, 4'b0000);
        step("lu_c3", 4'b0000, 4'b0000, 4'b0000);
        step("lu_c4", 4'b0000, 4'b0000, 4'b0000);
        check_perf("lu", 3, 1, 0);

        // Branch in the second stall cycle aborts the stall
        set_lu();
        step("br_c0", 4'b0000, 4'b1101, 4'b1101);
        clear_inputs();
        br_taken = 1'b1;
        step("br_c1", 4'b0000, 4'b0011, 4'b0011);
        br_taken = 1'b0;
        step("br_c2", 4'b0000, 4'b0000, 4'b0000);
        step("br_c3", 4'b0000, 4'b0000, 4'b0000);

        // Load-use and branch in the same cycle: branch wins, no stall follows
        set_lu();
        br_taken = 1'b1;
        step("lubr_c0", 4'b0000, 4'b0011, 4'b0011);
        clear_inputs();
        step("lubr_c1", 4'b0000, 4'b0000, 4'b0000);
        check_perf("br", 4, 2, 2);

        // Asynchronous reset while LAT3 is in STALL
        set_lu();
        me_rd = 5'd1; me_ruwr = 1'b1; ex_rs = {5'd0, 5'd1};
        step("rst_c0", 4'b0001, 4'b1101, 4'b1101);
        ex_is_load = 1'b0; ex_ruwr = 1'b0; ex_rd = '0; id_rs = '0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.fwd3", 32'(fwd3), 32'd0);
        check("mid_rst.fwd1", 32'(fwd1), 32'd0);
        check("mid_rst.ctl3", 32'(ctl3), 32'd0);
        check("mid_rst.ctl1", 32'(ctl1), 32'd0);
        check_perf("mid_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        step("post_rst", 4'b0000, 4'b0000, 4'b0000);
        check_perf("post_rst", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised successor to the pipeline forwarding unit. It combines per-source operand forwarding with load-use stall insertion, driven by a registered stall FSM with configurable bubble count. It also handles taken-branch flushes. It sits beside the ID/EX/ME/WB pipeline registers and drives the EX operand muxes plus the PC, IF/ID and ID/EX control.

Parameters:
REG_ADDR_W, 5, register index width
NUM_SRC, 2, source operands per instruction (rs1..rsN)
LOAD_LAT, 1, bubbles inserted on load-use (1..7); 1 = single-cycle data memory
CNT_W, 32, perf counter width (optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs  in  NUM_SRC*REG_ADDR_W  ID-stage source indices, src0 in LSBs
ex_rs  in  NUM_SRC*REG_ADDR_W  EX-stage source indices
ex_rd  in  REG_ADDR_W  EX destination
ex_ruwr  in  1  EX writes register file
ex_is_load  in  1  EX instruction is a load
me_rd  in  REG_ADDR_W  ME destination
me_ruwr  in  1  ME writes register file
wb_rd  in  REG_ADDR_W  WB destination
wb_ruwr  in  1  WB writes register file
br_taken  in  1  taken branch/jump resolved in EX
fwd_sel  out  NUM_SRC*2  per-source EX mux select: 00 regfile, 01 ME, 10 WB
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  insert bubble into ID/EX
stall_cycles  out  CNT_W  stall cycle count (optional feature)
flush_cycles  out  CNT_W  branch flush count (optional feature)

Behaviour:
- Forwarding is combinational, zero latency, evaluated per source i:
  - 01 when me_ruwr, me_rd!=0 and me_rd==ex_rs[i].
  - Otherwise 10 when wb_ruwr, wb_rd!=0 and wb_rd==ex_rs[i].
  - Otherwise 00.
  - ME has priority over WB. Code 11 is never driven.
- Load-use hazard (LU) = ex_is_load & ex_ruwr & ex_rd!=0 & (ex_rd==id_rs[i] for any i).
- FSM states: IDLE, STALL; 3-bit down-counter cnt.
  - IDLE, LU, no br_taken:
    - Assert pc_stall, if_id_stall and id_ex_flush in the same cycle (combinational).
    - If LOAD_LAT>1: next state STALL, cnt=LOAD_LAT-1. Otherwise stay in IDLE.
  - STALL:
    - Assert pc_stall, if_id_stall and id_ex_flush every cycle; cnt decrements.
    - When cnt==1 the current cycle is the last stall cycle; next state IDLE.
    - LU is not re-evaluated while in STALL.
- br_taken (any state) has priority:
  - Assert if_id_flush and id_ex_flush; pc_stall=if_id_stall=0 that cycle.
  - Next state IDLE, cnt=0; a stall in progress is aborted.
- Total bubbles per load-use event = LOAD_LAT exactly, absent branches.
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, counters=0.
  - pc_stall, if_id_stall, if_id_flush, id_ex_flush and fwd_sel are forced to 0 while rst_n is low.
- Reset asserted mid-stall: the stall is abandoned immediately; the first cycle after release is in IDLE.
- ex_rs and id_rs index 0 never cause forwarding or stalls.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined:
  - stall_cycles increments each cycle pc_stall=1.
  - flush_cycles increments each cycle br_taken=1.
  - Both saturate at all-ones and clear only on reset.
- Undefined: the counter registers are removed, ports remain, and both are tied to 0.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_ME=2'b01, FWD_WB=2'b10.
  - hz_state_e enum: IDLE, STALL.
  - Default REG_ADDR_W and the X0 constant.
- One sub-module, forward_select: a single-source comparator producing one fwd_sel_e. It is instantiated NUM_SRC times via generate.

Test Plan:
- Forwarding priority: ex_rs={2,1}, me_rd=1/me_ruwr=1, wb_rd=2/wb_ruwr=1 -> fwd_sel src0=01, src1=10. Then me_rd=wb_rd=1 with ex_rs0=1 -> src0=01 (ME wins).
- x0 and write-enable guard: me_rd=0, ex_rs0=0, me_ruwr=1 -> 00. wb_rd=3, wb_ruwr=0, ex_rs0=3 -> 00.
- Load-use, LOAD_LAT=1: ex_is_load=1, ex_rd=5, id_rs1=5 -> one cycle of pc_stall/if_id_stall/id_ex_flush=1, then 0 once the load leaves EX.
- Load-use, LOAD_LAT=3: single LU pulse -> exactly 3 consecutive stall cycles; state returns to IDLE; with HAZARD_PERF_CNT_EN, stall_cycles==3.
- Branch during stall, LOAD_LAT=3: br_taken=1 in the 2nd stall cycle -> that cycle if_id_flush=id_ex_flush=1 and pc_stall=0; next cycle no stall.
- Async reset mid-stall: drop rst_n in the STALL state -> all outputs 0 immediately; after release state is IDLE and the counters read 0.
